// File: rtl/weight_pingpong_buffer.sv
// rtl/weight_pingpong_buffer.sv - double-banked filter-weight buffer between memory and PE lanes
// One bank fills from 64-bit memory beats while the other streams row chunks to the PE lanes.
module weight_pingpong_buffer #(
  parameter int MEM_W     = 64,
  parameter int ROW_BYTES = 11,
  parameter int MAX_ROWS  = 44,
  parameter int LANES     = 6,
  parameter int CHUNK_W   = 32,
  localparam int BEATS  = (ROW_BYTES * 8 + MEM_W - 1) / MEM_W,
  localparam int CHUNKS = (ROW_BYTES * 8 + CHUNK_W - 1) / CHUNK_W,
  localparam int RW     = $clog2(MAX_ROWS + 1),
  localparam int LW     = $clog2(LANES + 1),
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start,
  input  logic [RW-1:0]            cfg_rows,
  output logic                     mem_req,
  input  logic                     mem_valid,
  input  logic [MEM_W-1:0]         mem_data,
  output logic                     load_done,
  output logic [1:0]               bank_full,
  input  logic                     out_start,
  input  logic [LW-1:0]            cfg_lanes,
  input  logic                     out_retain,
  input  logic                     out_stall,
  output logic [LANES-1:0]         out_valid,
  output logic [LANES*CHUNK_W-1:0] out_data,
  output logic [LANES*RW-1:0]      out_row,
  output logic [CW-1:0]            out_chunk,
  output logic                     out_last,
  input  logic                     free_rd
);

  localparam int BPB   = MEM_W / 8;
  localparam int ROW_W = ROW_BYTES * 8;
  localparam int PAD_W = CHUNKS * CHUNK_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int XW    = $clog2(MAX_ROWS + LANES + 1);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_STREAM} rstate_t;

  logic [ROW_W-1:0] ram [0:1][0:MAX_ROWS-1];

  wstate_t         wstate;
  logic            wr_bank;
  logic [RW-1:0]   wrow;
  logic [BW-1:0]   wbeat;
  logic [RW-1:0]   rows [0:1];

  rstate_t         rstate;
  logic            rd_bank;
  logic [LW-1:0]   rlanes;
  logic [RW-1:0]   rrows;
  logic            retain;
  logic [XW-1:0]   rbase;
  logic [CW-1:0]   rchunk;

  logic                     r_accept;
  logic                     consume;
  logic [LW-1:0]            sel_lanes;
  logic [RW-1:0]            sel_rows;
  logic [XW-1:0]            sel_base;
  logic [CW-1:0]            sel_chunk;
  logic [XW-1:0]            lane_row;
  logic [PAD_W-1:0]         padded;
  logic [LANES-1:0]         nxt_valid;
  logic [LANES*CHUNK_W-1:0] nxt_data;
  logic [LANES*RW-1:0]      nxt_row;
  logic                     nxt_last;

  // Out-of-range configuration is clamped to the nearest legal value.
  function automatic logic [RW-1:0] clamp_rows(input logic [RW-1:0] r);
    if (r == '0) return RW'(1);
    if (r > RW'(MAX_ROWS)) return RW'(MAX_ROWS);
    return r;
  endfunction

  function automatic logic [LW-1:0] clamp_lanes(input logic [LW-1:0] l);
    if (l == '0) return LW'(1);
    if (l > LW'(LANES)) return LW'(LANES);
    return l;
  endfunction

  // Bytes past ROW_BYTES in the last beat of a row are simply never written.
  always_ff @(posedge clk) begin
    if (rst_n && mem_req && mem_valid) begin
      for (int k = 0; k < ROW_BYTES; k++) begin
        if (k / BPB == int'(wbeat))
          ram[wr_bank][wrow][k*8 +: 8] <= mem_data[(k % BPB)*8 +: 8];
      end
    end
  end

  assign r_accept = (rstate == R_IDLE) && out_start && bank_full[rd_bank];
  assign consume  = (rstate == R_STREAM) && (|out_valid) && !out_stall;

  // Next beat to present: either the first beat of a new stream or the successor of the current one.
  always_comb begin
    sel_lanes = rlanes;
    sel_rows  = rrows;
    sel_base  = rbase;
    sel_chunk = rchunk;
    lane_row  = '0;
    padded    = '0;
    nxt_valid = '0;
    nxt_data  = '0;
    nxt_row   = '0;
    if (r_accept) begin
      sel_lanes = clamp_lanes(cfg_lanes);
      sel_rows  = rows[rd_bank];
      sel_base  = '0;
      sel_chunk = CW'(CHUNKS - 1);
    end else if (rchunk == '0) begin
      sel_base  = rbase + XW'(rlanes);
      sel_chunk = CW'(CHUNKS - 1);
    end else begin
      sel_chunk = rchunk - 1'b1;
    end
    for (int i = 0; i < LANES; i++) begin
      lane_row = sel_base + XW'(i);
      if (XW'(i) < XW'(sel_lanes) && lane_row < XW'(sel_rows)) begin
        padded = PAD_W'(ram[rd_bank][lane_row[RW-1:0]]);
        nxt_valid[i] = 1'b1;
        nxt_row[i*RW +: RW] = lane_row[RW-1:0];
        for (int c = 0; c < CHUNKS; c++) begin
          if (sel_chunk == CW'(c))
            nxt_data[i*CHUNK_W +: CHUNK_W] = padded[c*CHUNK_W +: CHUNK_W];
        end
      end
    end
    nxt_last = (sel_chunk == '0) && (sel_base + XW'(sel_lanes) >= XW'(sel_rows));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate    <= W_IDLE;
      wr_bank   <= 1'b0;
      wrow      <= '0;
      wbeat     <= '0;
      rows[0]   <= '0;
      rows[1]   <= '0;
      mem_req   <= 1'b0;
      load_done <= 1'b0;
      bank_full <= 2'b00;
      rstate    <= R_IDLE;
      rd_bank   <= 1'b0;
      rlanes    <= '0;
      rrows     <= '0;
      retain    <= 1'b0;
      rbase     <= '0;
      rchunk    <= '0;
      out_valid <= '0;
      out_data  <= '0;
      out_row   <= '0;
      out_chunk <= '0;
      out_last  <= 1'b0;
    end else begin
      load_done <= 1'b0;

      case (wstate)
        W_IDLE: begin
          if (load_start && !bank_full[wr_bank]) begin
            rows[wr_bank] <= clamp_rows(cfg_rows);
            wrow    <= '0;
            wbeat   <= '0;
            mem_req <= 1'b1;
            wstate  <= W_FILL;
          end
        end
        W_FILL: begin
          if (mem_valid) begin
            if (wbeat == BW'(BEATS - 1)) begin
              wbeat <= '0;
              if (wrow == rows[wr_bank] - 1'b1) begin
                bank_full[wr_bank] <= 1'b1;
                load_done <= 1'b1;
                wr_bank   <= ~wr_bank;
                mem_req   <= 1'b0;
                wstate    <= W_IDLE;
              end else begin
                wrow <= wrow + 1'b1;
              end
            end else begin
              wbeat <= wbeat + 1'b1;
            end
          end
        end
        default: wstate <= W_IDLE;
      endcase

      // The write side only ever targets a non-full bank and the read side a full one,
      // so the two bank_full updates below never collide on the same bit.
      case (rstate)
        R_IDLE: begin
          if (r_accept) begin
            rlanes    <= sel_lanes;
            rrows     <= sel_rows;
            retain    <= out_retain;
            rbase     <= sel_base;
            rchunk    <= sel_chunk;
            out_valid <= nxt_valid;
            out_data  <= nxt_data;
            out_row   <= nxt_row;
            out_chunk <= sel_chunk;
            out_last  <= nxt_last;
            rstate    <= R_STREAM;
          end else if (free_rd && bank_full[rd_bank]) begin
            bank_full[rd_bank] <= 1'b0;
            rd_bank <= ~rd_bank;
          end
        end
        R_STREAM: begin
          if (consume) begin
            if (out_last) begin
              out_valid <= '0;
              out_data  <= '0;
              out_row   <= '0;
              out_chunk <= '0;
              out_last  <= 1'b0;
              rstate    <= R_IDLE;
              if (!retain) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank <= ~rd_bank;
              end
            end else begin
              rbase     <= sel_base;
              rchunk    <= sel_chunk;
              out_valid <= nxt_valid;
              out_data  <= nxt_data;
              out_row   <= nxt_row;
              out_chunk <= sel_chunk;
              out_last  <= nxt_last;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// tb/tb_weight_pingpong_buffer.sv - directed self-checking bench for weight_pingpong_buffer
module tb_weight_pingpong_buffer;

  localparam int MEM_W     = 64;
  localparam int ROW_BYTES = 11;
  localparam int MAX_ROWS  = 44;
  localparam int LANES     = 6;
  localparam int CHUNK_W   = 32;
  localparam int BEATS     = 2;
  localparam int CHUNKS    = 3;
  localparam int RW        = 6;
  localparam int LW        = 3;
  localparam int CW        = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     load_start;
  logic [RW-1:0]            cfg_rows;
  logic                     mem_req;
  logic                     mem_valid;
  logic [MEM_W-1:0]         mem_data;
  logic                     load_done;
  logic [1:0]               bank_full;
  logic                     out_start;
  logic [LW-1:0]            cfg_lanes;
  logic                     out_retain;
  logic                     out_stall;
  logic [LANES-1:0]         out_valid;
  logic [LANES*CHUNK_W-1:0] out_data;
  logic [LANES*RW-1:0]      out_row;
  logic [CW-1:0]            out_chunk;
  logic                     out_last;
  logic                     free_rd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [LANES-1:0]         q_valid [$];
  logic [LANES*CHUNK_W-1:0] q_data  [$];
  logic [LANES*RW-1:0]      q_row   [$];
  int                       q_chunk [$];
  bit                       q_last  [$];

  logic [LANES-1:0]         ev;
  logic [LANES*CHUNK_W-1:0] ed;
  logic [LANES*RW-1:0]      er;
  int                       ec;
  bit                       el;

  int beats, reqc, done_s, unst, tmo;

  weight_pingpong_buffer dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .cfg_rows(cfg_rows),
    .mem_req(mem_req), .mem_valid(mem_valid), .mem_data(mem_data), .load_done(load_done),
    .bank_full(bank_full), .out_start(out_start), .cfg_lanes(cfg_lanes), .out_retain(out_retain),
    .out_stall(out_stall), .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
    .out_chunk(out_chunk), .out_last(out_last), .free_rd(free_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rbyte(input int tag, input int r, input int k);
    return 8'((tag * 53 + r * ROW_BYTES + k) & 255);
  endfunction

  // Bytes beyond the row are filled with 0xEE so any leak into the buffer shows up.
  function automatic logic [MEM_W-1:0] beat_word(input int tag, input int r, input int b);
    logic [MEM_W-1:0] w;
    int k;
    for (int j = 0; j < MEM_W / 8; j++) begin
      k = b * (MEM_W / 8) + j;
      w[j*8 +: 8] = (k < ROW_BYTES) ? rbyte(tag, r, k) : 8'hEE;
    end
    return w;
  endfunction

  function automatic logic [CHUNK_W-1:0] lane_word(input int tag, input int r, input int c);
    logic [CHUNK_W-1:0] w;
    int k;
    w = '0;
    for (int j = 0; j < CHUNK_W / 8; j++) begin
      k = c * (CHUNK_W / 8) + j;
      if (k < ROW_BYTES) w[j*8 +: 8] = rbyte(tag, r, k);
    end
    return w;
  endfunction

  task automatic exp_beat(input int tag, input int rows, input int lanes, input int n,
                          output logic [LANES-1:0] v, output logic [LANES*CHUNK_W-1:0] d,
                          output logic [LANES*RW-1:0] r, output int c, output bit last);
    int grp_n, g, row;
    grp_n = (rows + lanes - 1) / lanes;
    g = n / CHUNKS;
    c = CHUNKS - 1 - (n % CHUNKS);
    v = '0; d = '0; r = '0;
    for (int i = 0; i < LANES; i++) begin
      row = g * lanes + i;
      if (i < lanes && row < rows) begin
        v[i] = 1'b1;
        d[i*CHUNK_W +: CHUNK_W] = lane_word(tag, row, c);
        r[i*RW +: RW] = RW'(row);
      end
    end
    last = (g == grp_n - 1) && (c == 0);
  endtask

  task automatic do_fill(input int tag, input int nrows, input int gap_mod, input int max_beats,
                         output int nb, output int req_cycles, output int done_seen);
    int idx, cyc;
    idx = 0; cyc = 0; req_cycles = 0; done_seen = 0;
    @(negedge clk);
    load_start = 1'b1;
    cfg_rows = RW'(nrows);
    @(negedge clk);
    load_start = 1'b0;
    while (cyc < 3000) begin
      if (load_done) begin
        done_seen = 1;
        break;
      end
      if (idx >= max_beats) break;
      if (mem_req) begin
        req_cycles++;
        mem_valid = (gap_mod == 0) || (cyc % gap_mod != 0);
        mem_data = beat_word(tag, idx / BEATS, idx % BEATS);
        if (mem_valid) idx++;
      end else begin
        mem_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    mem_valid = 1'b0;
    nb = idx;
  endtask

  task automatic do_stream(input int lanes, input int ret, input int stall_mode,
                           output int unstable, output int timeout);
    logic [LANES-1:0] sv;
    logic [LANES*CHUNK_W-1:0] sd;
    logic [LANES*RW-1:0] sr;
    logic [CW-1:0] sc;
    logic sl;
    bit prev_stall, done, stall;
    int cyc;
    q_valid.delete(); q_data.delete(); q_row.delete(); q_chunk.delete(); q_last.delete();
    unstable = 0; prev_stall = 0; done = 0; cyc = 0;
    sv = '0; sd = '0; sr = '0; sc = '0; sl = 1'b0;
    @(negedge clk);
    out_start = 1'b1;
    cfg_lanes = LW'(lanes);
    out_retain = (ret != 0);
    @(negedge clk);
    out_start = 1'b0;
    while (!done && cyc < 400) begin
      if (prev_stall && {out_valid, out_data, out_row, out_chunk, out_last} !== {sv, sd, sr, sc, sl})
        unstable++;
      stall = (stall_mode != 0) && (cyc % 2 == 0);
      out_stall = stall;
      if (!stall && out_valid != '0) begin
        q_valid.push_back(out_valid);
        q_data.push_back(out_data);
        q_row.push_back(out_row);
        q_chunk.push_back(int'(out_chunk));
        q_last.push_back(out_last);
        if (out_last) done = 1;
      end
      {sv, sd, sr, sc, sl} = {out_valid, out_data, out_row, out_chunk, out_last};
      prev_stall = stall;
      @(negedge clk);
      cyc++;
    end
    out_stall = 1'b0;
    timeout = done ? 0 : 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 0; cfg_rows = '0; mem_valid = 0; mem_data = '0;
    out_start = 0; cfg_lanes = '0; out_retain = 0; out_stall = 0; free_rd = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_req, load_done, bank_full} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req, load_done, bank_full});
    end
    n_cmp++;
    if ({out_valid, out_data, out_row, out_chunk, out_last} !== '0) begin
      n_bad++; $display("FAIL reset_out: got v=%b d=%h want all zero", out_valid, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, bank_full, out_valid} !== '0) begin
      n_bad++; $display("FAIL reset_release: got req=%b full=%b v=%b want 0", mem_req, bank_full, out_valid);
    end
  endtask

  task automatic test_full_bank();
    do_fill(0, 44, 0, 1000, beats, reqc, done_s);
    n_cmp++;
    if (beats != 88 || reqc != 88 || done_s != 1) begin
      n_bad++; $display("FAIL full_fill: got beats=%0d req=%0d done=%0d want 88 88 1", beats, reqc, done_s);
    end
    n_cmp++;
    if (bank_full !== 2'b01 || mem_req !== 1'b0) begin
      n_bad++; $display("FAIL full_flags: got full=%b req=%b want 01 0", bank_full, mem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (load_done !== 1'b0) begin
      n_bad++; $display("FAIL full_done_pulse: got %b want 0", load_done);
    end
    do_stream(6, 0, 0, unst, tmo);
    n_cmp++;
    if (tmo != 0 || q_data.size() != 24) begin
      n_bad++; $display("FAIL full_count: got tmo=%0d beats=%0d want 0 24", tmo, q_data.size());
    end
    for (int n = 0; n < q_data.size(); n++) begin
      exp_beat(0, 44, 6, n, ev, ed, er, ec, el);
      n_cmp++;
      if (q_valid[n] !== ev || q_data[n] !== ed || q_row[n] !== er || q_chunk[n] != ec || q_last[n] != el) begin
        n_bad++;
        $display("FAIL full_beat%0d: got v=%h c=%0d l=%0d d=%h r=%h want v=%h c=%0d l=%0d d=%h r=%h",
                 n, q_valid[n], q_chunk[n], q_last[n], q_data[n], q_row[n], ev, ec, el, ed, er);
      end
    end
    if (q_data.size() == 24) begin
      n_cmp++;
      if (q_data[0][31:0] !== 32'h000A0908 || q_data[1][31:0] !== 32'h07060504 || q_data[2][31:0] !== 32'h03020100) begin
        n_bad++; $display("FAIL full_row0: got %h %h %h want 000a0908 07060504 03020100",
                          q_data[0][31:0], q_data[1][31:0], q_data[2][31:0]);
      end
      n_cmp++;
      if (q_valid[21] !== 6'b000011 || q_row[21][11:0] !== {6'd43, 6'd42} || q_last[23] != 1'b1 || q_last[22] != 1'b0) begin
        n_bad++; $display("FAIL full_group7: got v=%b rows=%h last22=%0d last23=%0d want 000011 %h 0 1",
                          q_valid[21], q_row[21][11:0], q_last[22], q_last[23], {6'd43, 6'd42});
      end
    end
    n_cmp++;
    if (bank_full !== 2'b00 || out_valid !== '0 || out_last !== 1'b0) begin
      n_bad++; $display("FAIL full_release: got full=%b v=%b last=%b want 00 0 0", bank_full, out_valid, out_last);
    end
  endtask

  task automatic test_stall();
    do_fill(1, 11, 3, 1000, beats, reqc, done_s);
    n_cmp++;
    if (done_s != 1 || bank_full !== 2'b10) begin
      n_bad++; $display("FAIL stall_fill: got done=%0d full=%b want 1 10", done_s, bank_full);
    end
    do_stream(3, 0, 1, unst, tmo);
    n_cmp++;
    if (tmo != 0 || q_data.size() != 12 || unst != 0) begin
      n_bad++; $display("FAIL stall_count: got tmo=%0d beats=%0d unstable=%0d want 0 12 0", tmo, q_data.size(), unst);
    end
    for (int n = 0; n < q_data.size(); n++) begin
      exp_beat(1, 11, 3, n, ev, ed, er, ec, el);
      n_cmp++;
      if (q_valid[n] !== ev || q_data[n] !== ed || q_row[n] !== er || q_chunk[n] != ec || q_last[n] != el) begin
        n_bad++;
        $display("FAIL stall_beat%0d: got v=%h c=%0d l=%0d d=%h r=%h want v=%h c=%0d l=%0d d=%h r=%h",
                 n, q_valid[n], q_chunk[n], q_last[n], q_data[n], q_row[n], ev, ec, el, ed, er);
      end
    end
    if (q_valid.size() == 12) begin
      n_cmp++;
      if (q_valid[9] !== 6'b000011) begin
        n_bad++; $display("FAIL stall_lastgroup: got %b want 000011", q_valid[9]);
      end
    end
    n_cmp++;
    if (bank_full !== 2'b00) begin
      n_bad++; $display("FAIL stall_release: got %b want 00", bank_full);
    end
  endtask

  task automatic test_pingpong();
    int fb, fr, fd, seen;
    do_fill(2, 20, 0, 1000, beats, reqc, done_s);
    n_cmp++;
    if (done_s != 1 || bank_full !== 2'b01) begin
      n_bad++; $display("FAIL pp_fill0: got done=%0d full=%b want 1 01", done_s, bank_full);
    end
    fork
      do_stream(4, 0, 0, unst, tmo);
      do_fill(3, 30, 2, 1000, fb, fr, fd);
    join
    n_cmp++;
    if (tmo != 0 || q_data.size() != 15 || fd != 1 || fb != 60) begin
      n_bad++; $display("FAIL pp_concurrent: got tmo=%0d beats=%0d done=%0d fill=%0d want 0 15 1 60",
                        tmo, q_data.size(), fd, fb);
    end
    for (int n = 0; n < q_data.size(); n++) begin
      exp_beat(2, 20, 4, n, ev, ed, er, ec, el);
      n_cmp++;
      if (q_valid[n] !== ev || q_data[n] !== ed || q_row[n] !== er || q_chunk[n] != ec || q_last[n] != el) begin
        n_bad++;
        $display("FAIL pp_bank0_beat%0d: got v=%h c=%0d l=%0d d=%h r=%h want v=%h c=%0d l=%0d d=%h r=%h",
                 n, q_valid[n], q_chunk[n], q_last[n], q_data[n], q_row[n], ev, ec, el, ed, er);
      end
    end
    n_cmp++;
    if (bank_full !== 2'b10) begin
      n_bad++; $display("FAIL pp_flags: got %b want 10", bank_full);
    end
    do_fill(4, 5, 0, 1000, beats, reqc, done_s);
    n_cmp++;
    if (done_s != 1 || bank_full !== 2'b11) begin
      n_bad++; $display("FAIL pp_both_full: got done=%0d full=%b want 1 11", done_s, bank_full);
    end
    @(negedge clk);
    load_start = 1'b1;
    cfg_rows = RW'(9);
    @(negedge clk);
    load_start = 1'b0;
    seen = 0;
    repeat (4) begin
      if (mem_req || load_done) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 0 || bank_full !== 2'b11) begin
      n_bad++; $display("FAIL pp_third_load: got req_cycles=%0d full=%b want 0 11", seen, bank_full);
    end
    do_stream(5, 0, 0, unst, tmo);
    n_cmp++;
    if (tmo != 0 || q_data.size() != 18) begin
      n_bad++; $display("FAIL pp_bank1_count: got tmo=%0d beats=%0d want 0 18", tmo, q_data.size());
    end
    for (int n = 0; n < q_data.size(); n++) begin
      exp_beat(3, 30, 5, n, ev, ed, er, ec, el);
      n_cmp++;
      if (q_valid[n] !== ev || q_data[n] !== ed || q_row[n] !== er || q_chunk[n] != ec || q_last[n] != el) begin
        n_bad++;
        $display("FAIL pp_bank1_beat%0d: got v=%h c=%0d l=%0d d=%h r=%h want v=%h c=%0d l=%0d d=%h r=%h",
                 n, q_valid[n], q_chunk[n], q_last[n], q_data[n], q_row[n], ev, ec, el, ed, er);
      end
    end
    n_cmp++;
    if (bank_full !== 2'b01) begin
      n_bad++; $display("FAIL pp_final_flags: got %b want 01", bank_full);
    end
  endtask

  task automatic test_retain();
    logic [LANES-1:0]         f_valid [$];
    logic [LANES*CHUNK_W-1:0] f_data  [$];
    logic [LANES*RW-1:0]      f_row   [$];
    do_stream(6, 1, 0, unst, tmo);
    n_cmp++;
    if (tmo != 0 || q_data.size() != 3 || bank_full !== 2'b01) begin
      n_bad++; $display("FAIL retain_first: got tmo=%0d beats=%0d full=%b want 0 3 01", tmo, q_data.size(), bank_full);
    end
    for (int n = 0; n < q_data.size(); n++) begin
      exp_beat(4, 5, 6, n, ev, ed, er, ec, el);
      n_cmp++;
      if (q_valid[n] !== ev || q_data[n] !== ed || q_row[n] !== er || q_chunk[n] != ec || q_last[n] != el) begin
        n_bad++;
        $display("FAIL retain_beat%0d: got v=%h c=%0d l=%0d d=%h r=%h want v=%h c=%0d l=%0d d=%h r=%h",
                 n, q_valid[n], q_chunk[n], q_last[n], q_data[n], q_row[n], ev, ec, el, ed, er);
      end
    end
    f_valid = q_valid; f_data = q_data; f_row = q_row;
    do_stream(6, 1, 0, unst, tmo);
    n_cmp++;
    if (tmo != 0 || q_data.size() != f_data.size() || bank_full !== 2'b01) begin
      n_bad++; $display("FAIL retain_replay: got tmo=%0d beats=%0d full=%b want 0 %0d 01",
                        tmo, q_data.size(), bank_full, f_data.size());
    end
    for (int n = 0; n < q_data.size() && n < f_data.size(); n++) begin
      n_cmp++;
      if (q_valid[n] !== f_valid[n] || q_data[n] !== f_data[n] || q_row[n] !== f_row[n]) begin
        n_bad++; $display("FAIL retain_same%0d: got d=%h want d=%h", n, q_data[n], f_data[n]);
      end
    end
    @(negedge clk);
    free_rd = 1'b1;
    @(negedge clk);
    free_rd = 1'b0;
    n_cmp++;
    if (bank_full !== 2'b00) begin
      n_bad++; $display("FAIL retain_free: got %b want 00", bank_full);
    end
    do_fill(5, 7, 0, 1000, beats, reqc, done_s);
    do_stream(2, 0, 0, unst, tmo);
    n_cmp++;
    if (done_s != 1 || tmo != 0 || q_data.size() != 12 || bank_full !== 2'b00) begin
      n_bad++; $display("FAIL retain_toggle: got done=%0d tmo=%0d beats=%0d full=%b want 1 0 12 00",
                        done_s, tmo, q_data.size(), bank_full);
    end
    for (int n = 0; n < q_data.size(); n++) begin
      exp_beat(5, 7, 2, n, ev, ed, er, ec, el);
      n_cmp++;
      if (q_valid[n] !== ev || q_data[n] !== ed || q_row[n] !== er || q_chunk[n] != ec || q_last[n] != el) begin
        n_bad++;
        $display("FAIL toggle_beat%0d: got v=%h c=%0d l=%0d d=%h r=%h want v=%h c=%0d l=%0d d=%h r=%h",
                 n, q_valid[n], q_chunk[n], q_last[n], q_data[n], q_row[n], ev, ec, el, ed, er);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    do_fill(6, 40, 0, 10, beats, reqc, done_s);
    n_cmp++;
    if (beats != 10 || mem_req !== 1'b1) begin
      n_bad++; $display("FAIL midrst_partial: got beats=%0d req=%b want 10 1", beats, mem_req);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0 || bank_full !== 2'b00) begin
      n_bad++; $display("FAIL midrst_state: got req=%b full=%b want 0 00", mem_req, bank_full);
    end
    rst_n = 1'b1;
    do_fill(7, 19, 0, 1000, beats, reqc, done_s);
    n_cmp++;
    if (done_s != 1 || beats != 38 || bank_full !== 2'b01) begin
      n_bad++; $display("FAIL midrst_refill: got done=%0d beats=%0d full=%b want 1 38 01", done_s, beats, bank_full);
    end
    do_stream(6, 0, 0, unst, tmo);
    n_cmp++;
    if (tmo != 0 || q_data.size() != 12) begin
      n_bad++; $display("FAIL midrst_count: got tmo=%0d beats=%0d want 0 12", tmo, q_data.size());
    end
    for (int n = 0; n < q_data.size(); n++) begin
      exp_beat(7, 19, 6, n, ev, ed, er, ec, el);
      n_cmp++;
      if (q_valid[n] !== ev || q_data[n] !== ed || q_row[n] !== er || q_chunk[n] != ec || q_last[n] != el) begin
        n_bad++;
        $display("FAIL midrst_beat%0d: got v=%h c=%0d l=%0d d=%h r=%h want v=%h c=%0d l=%0d d=%h r=%h",
                 n, q_valid[n], q_chunk[n], q_last[n], q_data[n], q_row[n], ev, ec, el, ed, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_bank();
    test_stall();
    test_pingpong();
    test_retain();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
